leaf_stream_packetizer: RTL and testbench

Transmit-side packetizer for one user output stream of a leaf. It accepts 32-bit words from the user kernel over a valid/ready handshake and wraps each word in a 49-bit BFT packet addressed to a configured destination leaf and input port. It stamps each packet with the receiver's BRAM slot address. It enforces credit-based flow control against the receiving leaf's input buffer, which returns free-space updates in fixed-size chunks. One instance sits between each user `Output_N` stream and the leaf's BFT-side output arbiter.

---
 rtl/leaf_stream_packetizer_if.sv | 43 ++++
 rtl/leaf_stream_packetizer.sv | 159 +++++++++++++++
 tb/tb_leaf_stream_packetizer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/leaf_stream_packetizer_if.sv
`default_nettype none
// ============================================================================
//  Module      : leaf_stream_packetizer_if
//  Description : Stream bundle between a user kernel output, the packetizer
//                and the leaf's BFT-side output arbiter. It carries the user
//                word handshake (data / valid / ack) and the packet output
//                with its grant.
//  Signals     : din_leaf_user2interface  user word into the packetizer
//                vld_user2interface       user word valid
//                ack_interface2user       packetizer ready to the user
//                dout_leaf_interface2bft  registered packet to the arbiter
//                grant                    arbiter consumes the packet
//  Modports    : master - kernel/arbiter side (drives data, valid, grant)
//                slave  - packetizer side (drives ack and packet)
//  Revision    : 1.0 - initial release
// ============================================================================
interface leaf_stream_packetizer_if #(
    parameter int PAYLOAD_BITS = 32,
    parameter int PACKET_BITS  = 49
);
    logic [PAYLOAD_BITS-1:0] din_leaf_user2interface;
    logic                    vld_user2interface;
    logic                    ack_interface2user;
    logic [PACKET_BITS-1:0]  dout_leaf_interface2bft;
    logic                    grant;

    modport master (
        output din_leaf_user2interface,
        output vld_user2interface,
        input  ack_interface2user,
        input  dout_leaf_interface2bft,
        output grant
    );

    modport slave (
        input  din_leaf_user2interface,
        input  vld_user2interface,
        output ack_interface2user,
        output dout_leaf_interface2bft,
        input  grant
    );
endinterface
`default_nettype wire

// File: rtl/leaf_stream_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : leaf_stream_packetizer
//  Description : Transmit-side packetizer for one user output stream of a
//                leaf. Wraps each accepted 32-bit user word in a BFT packet
//                {valid, dest leaf, dest port, receiver BRAM slot, payload}
//                and meters traffic with credits mirroring the free space of
//                the receiving leaf's input buffer.
//  Ports       : ap_clk            clock, rising edge
//                ap_rst_n          asynchronous active-low reset
//                cfg_wr            strobe: load destination, clear slot
//                                  address, restore full credit
//                cfg_dest_leaf     destination leaf
//                cfg_dest_port     destination input port
//                freespace_update  receiver freed FREESPACE_UPDATE_SIZE slots
//                credit_err        sticky credit-overflow flag
//                strm (slave)      user word handshake and packet/grant
//  Revision    : 1.0 - initial release
// ============================================================================
module leaf_stream_packetizer #(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_BRAM_ADDR_BITS    = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic                     cfg_wr,
    input  logic [NUM_LEAF_BITS-1:0] cfg_dest_leaf,
    input  logic [NUM_PORT_BITS-1:0] cfg_dest_port,
    input  logic                     freespace_update,
    output logic                     credit_err,
    leaf_stream_packetizer_if.slave  strm
);

    // Credit counts 0..2^ADDR inclusive, so it needs one bit more than the
    // slot address. The pre-clamp sum gets one further bit of headroom so a
    // full-credit update cannot wrap before the overflow compare sees it.
    localparam int CREDIT_BITS = NUM_BRAM_ADDR_BITS + 1;
    localparam int SUM_BITS    = CREDIT_BITS + 1;

    localparam logic [CREDIT_BITS-1:0] CREDIT_MAX  = CREDIT_BITS'(1 << NUM_BRAM_ADDR_BITS);
    localparam logic [SUM_BITS-1:0]    SUM_MAX     = SUM_BITS'(1 << NUM_BRAM_ADDR_BITS);
    localparam logic [SUM_BITS-1:0]    UPDATE_SIZE = SUM_BITS'(FREESPACE_UPDATE_SIZE);

    typedef enum logic [1:0] {
        ST_UNCFG = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    state_t                        state_q;
    logic [NUM_LEAF_BITS-1:0]      leaf_q;
    logic [NUM_PORT_BITS-1:0]      port_q;
    logic [NUM_BRAM_ADDR_BITS-1:0] addr_q;
    logic [CREDIT_BITS-1:0]        credit_q;
    logic [CREDIT_BITS-1:0]        credit_d;
    logic                          credit_err_q;
    logic [PACKET_BITS-1:0]        dout_q;

    logic                          out_vld;
    logic                          ack;
    logic                          accept;
    logic [SUM_BITS-1:0]           credit_sum;
    logic                          credit_ovf;

    // The valid flag is the packet MSB; the register is all zeros whenever
    // it holds nothing, so the MSB alone tells occupancy.
    assign out_vld = dout_q[PACKET_BITS-1];

    // Ready looks through grant: a held packet leaving this cycle frees the
    // register for the next word, giving one packet per cycle under grant.
    assign ack    = (state_q == ST_RUN) && (credit_q != '0) && (!out_vld || strm.grant);
    assign accept = strm.vld_user2interface && ack;

    // Credit: consume one per accepted word, restore a chunk per update.
    // Accept only happens with credit >= 1, so the subtraction never wraps.
    always_comb begin
        credit_sum = SUM_BITS'(credit_q);
        if (freespace_update) begin
            credit_sum = credit_sum + UPDATE_SIZE;
        end
        if (accept) begin
            credit_sum = credit_sum - SUM_BITS'(1);
        end
        credit_ovf = (credit_sum > SUM_MAX);

        // A destination load always restores the full window.
        if (cfg_wr || credit_ovf) begin
            credit_d = CREDIT_MAX;
        end else begin
            credit_d = credit_sum[CREDIT_BITS-1:0];
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q      <= ST_UNCFG;
            leaf_q       <= '0;
            port_q       <= '0;
            addr_q       <= '0;
            credit_q     <= CREDIT_MAX;
            credit_err_q <= 1'b0;
            dout_q       <= '0;
        end else begin
            credit_q     <= credit_d;
            credit_err_q <= credit_err_q | credit_ovf;

            // State follows the next credit value so that RUN/STALL always
            // agree with the credit register in the same cycle; an update in
            // a stalled cycle re-enables ready on the very next cycle.
            case (state_q)
                ST_UNCFG: begin
                    if (cfg_wr) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (credit_d == '0) begin
                        state_q <= ST_STALL;
                    end
                end
                ST_STALL: begin
                    if (credit_d != '0) begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    state_q <= ST_UNCFG;
                end
            endcase

            if (cfg_wr) begin
                leaf_q <= cfg_dest_leaf;
                port_q <= cfg_dest_port;
                addr_q <= '0;
            end else if (accept) begin
                // Natural wrap of the slot address matches the ring buffer.
                addr_q <= addr_q + NUM_BRAM_ADDR_BITS'(1);
            end

            // The packet is built from the header as it stood before any
            // same-cycle reload, so a packet in flight keeps its old header.
            if (accept) begin
                dout_q <= {1'b1, leaf_q, port_q, addr_q, strm.din_leaf_user2interface};
            end else if (strm.grant) begin
                dout_q <= '0;
            end
        end
    end

    assign strm.ack_interface2user      = ack;
    assign strm.dout_leaf_interface2bft = dout_q;
    assign credit_err                   = credit_err_q;

endmodule
`default_nettype wire

// File: tb/tb_leaf_stream_packetizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_leaf_stream_packetizer
//  Description : Self-checking bench for leaf_stream_packetizer. Accepted
//                words are turned into expected packets and queued; every
//                valid packet on the output is compared with the queue head
//                and popped when granted.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_leaf_stream_packetizer;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b1;
    logic        cfg_wr = 1'b0;
    logic [4:0]  cfg_dest_leaf = '0;
    logic [3:0]  cfg_dest_port = '0;
    logic        freespace_update = 1'b0;
    logic        credit_err;

    leaf_stream_packetizer_if bus ();

    leaf_stream_packetizer dut (
        .ap_clk           (ap_clk),
        .ap_rst_n         (ap_rst_n),
        .cfg_wr           (cfg_wr),
        .cfg_dest_leaf    (cfg_dest_leaf),
        .cfg_dest_port    (cfg_dest_port),
        .freespace_update (freespace_update),
        .credit_err       (credit_err),
        .strm             (bus.slave)
    );

    always #5 ap_clk = ~ap_clk;

    int          total = 0;
    int          bad   = 0;
    logic [48:0] sb[$];
    logic [4:0]  m_leaf = '0;
    logic [3:0]  m_port = '0;
    logic [6:0]  m_addr = '0;
    logic        ack_s;
    logic [48:0] dout_s;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, score the output, model any
    // accept, then return 1 time unit after the next rising edge.
    task automatic step();
        logic [48:0] e;
        @(negedge ap_clk);
        ack_s  = bus.ack_interface2user;
        dout_s = bus.dout_leaf_interface2bft;
        if (dout_s[48]) begin
            if (sb.size() == 0) begin
                chk("unexpected_pkt", 64'(dout_s), 64'd0);
            end else begin
                e = sb[0];
                chk("pkt", 64'(dout_s), 64'(e));
                if (bus.grant) void'(sb.pop_front());
            end
        end
        if (bus.vld_user2interface && ack_s) begin
            sb.push_back({1'b1, m_leaf, m_port, m_addr, bus.din_leaf_user2interface});
            m_addr++;
        end
        @(posedge ap_clk);
        #1;
    endtask

    task automatic cfg(input logic [4:0] leaf, input logic [3:0] port);
        cfg_dest_leaf = leaf;
        cfg_dest_port = port;
        cfg_wr = 1'b1;
        bus.vld_user2interface = 1'b0;
        step();
        cfg_wr = 1'b0;
        m_leaf = leaf;
        m_port = port;
        m_addr = '0;
    endtask

    initial begin
        int n;
        bus.din_leaf_user2interface = '0;
        bus.vld_user2interface      = 1'b0;
        bus.grant                   = 1'b0;

        // ---------------- reset state ----------------
        #1 ap_rst_n = 1'b0;
        #1;
        chk("rst_ack", 64'(bus.ack_interface2user), 64'd0);
        chk("rst_dout", 64'(bus.dout_leaf_interface2bft), 64'd0);
        chk("rst_err", 64'(credit_err), 64'd0);
        chk("rst_credit", 64'(dut.credit_q), 64'd128);
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        bus.vld_user2interface = 1'b1;
        bus.grant = 1'b1;
        bus.din_leaf_user2interface = 32'hA5A5_0001;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("uncfg_ack", 64'(ack_s), 64'd0);
            chk("uncfg_dout", 64'(dout_s), 64'd0);
        end

        // ---------------- basic send ----------------
        cfg(5'd5, 4'd3);
        bus.vld_user2interface = 1'b1;
        bus.din_leaf_user2interface = 32'hDEAD_BEEF;
        step();
        chk("basic_ack", 64'(ack_s), 64'd1);
        bus.din_leaf_user2interface = 32'h1234_5678;
        step();
        chk("basic_pkt0", 64'(dout_s), 64'({1'b1, 5'd5, 4'd3, 7'd0, 32'hDEAD_BEEF}));
        bus.vld_user2interface = 1'b0;
        step();
        chk("basic_pkt1", 64'(dout_s), 64'({1'b1, 5'd5, 4'd3, 7'd1, 32'h1234_5678}));
        step();

        // ---------------- credit exhaustion and wrap ----------------
        cfg(5'd9, 4'd7);
        bus.vld_user2interface = 1'b1;
        n = 0;
        for (int i = 0; i < 140; i++) begin
            bus.din_leaf_user2interface = $urandom;
            step();
            if (ack_s) n++;
            else break;
        end
        chk("exh_count", 64'(n), 64'd128);
        chk("exh_last_vld", 64'(dout_s[48]), 64'd1);
        chk("exh_last_addr", 64'(dout_s[38:32]), 64'd127);
        step();
        chk("stall_ack", 64'(ack_s), 64'd0);
        freespace_update = 1'b1;
        step();
        chk("stall_upd_cycle_ack", 64'(ack_s), 64'd0);
        freespace_update = 1'b0;
        bus.din_leaf_user2interface = 32'h0BAD_F00D;
        step();
        chk("resume_ack", 64'(ack_s), 64'd1);
        n = 1;
        for (int i = 0; i < 80; i++) begin
            bus.din_leaf_user2interface = $urandom;
            step();
            if (i == 0) chk("resume_addr0", 64'(dout_s[38:32]), 64'd0);
            if (ack_s) n++;
            else break;
        end
        chk("resume_count", 64'(n), 64'd64);
        bus.vld_user2interface = 1'b0;
        step();
        step();

        // ---------------- arbiter back-pressure ----------------
        cfg(5'd12, 4'd2);
        bus.grant = 1'b0;
        bus.vld_user2interface = 1'b1;
        bus.din_leaf_user2interface = 32'hCAFE_0001;
        step();
        chk("bp_first_ack", 64'(ack_s), 64'd1);
        bus.din_leaf_user2interface = 32'hCAFE_0002;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_hold_ack", 64'(ack_s), 64'd0);
            chk("bp_hold_pkt", 64'(dout_s), 64'({1'b1, 5'd12, 4'd2, 7'd0, 32'hCAFE_0001}));
        end
        bus.grant = 1'b1;
        step();
        chk("bp_release_ack", 64'(ack_s), 64'd1);
        bus.vld_user2interface = 1'b0;
        step();
        chk("bp_second_pkt", 64'(dout_s), 64'({1'b1, 5'd12, 4'd2, 7'd1, 32'hCAFE_0002}));

        // ---------------- simultaneous accept and update ----------------
        cfg(5'd3, 4'd9);
        bus.vld_user2interface = 1'b1;
        n = 0;
        for (int i = 0; i < 118; i++) begin
            bus.din_leaf_user2interface = $urandom;
            step();
            if (ack_s) n++;
        end
        chk("sim_count", 64'(n), 64'd118);
        chk("sim_credit10", 64'(dut.credit_q), 64'd10);
        freespace_update = 1'b1;
        step();
        freespace_update = 1'b0;
        bus.vld_user2interface = 1'b0;
        chk("sim_both_ack", 64'(ack_s), 64'd1);
        chk("sim_credit73", 64'(dut.credit_q), 64'd73);
        chk("sim_err_clear", 64'(credit_err), 64'd0);
        step();
        cfg(5'd3, 4'd9);
        bus.vld_user2interface = 1'b1;
        for (int i = 0; i < 28; i++) begin
            bus.din_leaf_user2interface = $urandom;
            step();
        end
        bus.vld_user2interface = 1'b0;
        chk("ovf_credit100", 64'(dut.credit_q), 64'd100);
        freespace_update = 1'b1;
        step();
        freespace_update = 1'b0;
        chk("ovf_credit_clamp", 64'(dut.credit_q), 64'd128);
        chk("ovf_err_set", 64'(credit_err), 64'd1);
        cfg(5'd3, 4'd9);
        chk("ovf_err_sticky", 64'(credit_err), 64'd1);

        // ---------------- async reset mid-stream ----------------
        cfg(5'd2, 4'd1);
        bus.grant = 1'b0;
        bus.vld_user2interface = 1'b1;
        bus.din_leaf_user2interface = 32'h5555_AAAA;
        step();
        bus.vld_user2interface = 1'b0;
        chk("arst_held", 64'(bus.dout_leaf_interface2bft[48]), 64'd1);
        ap_rst_n = 1'b0;
        #1;
        chk("arst_dout", 64'(bus.dout_leaf_interface2bft), 64'd0);
        chk("arst_ack", 64'(bus.ack_interface2user), 64'd0);
        chk("arst_err", 64'(credit_err), 64'd0);
        sb.delete();
        step();
        ap_rst_n = 1'b1;
        bus.grant = 1'b1;
        bus.vld_user2interface = 1'b1;
        step();
        chk("arst_uncfg_ack", 64'(ack_s), 64'd0);
        cfg(5'd2, 4'd1);
        bus.vld_user2interface = 1'b1;
        bus.din_leaf_user2interface = 32'h0000_0C0C;
        step();
        bus.vld_user2interface = 1'b0;
        step();
        chk("arst_restart", 64'(dout_s), 64'({1'b1, 5'd2, 4'd1, 7'd0, 32'h0000_0C0C}));
        step();
        chk("drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
